arm_ctrl_decoder: RTL

//  Instruction fetch/decode stage sitting directly upstream of the 8-bit ARM datapath.
//  - Takes the 24-bit instruction word at the current PC and produces registered control signals:

---
 rtl/arm_ctrl_decoder.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/arm_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// arm_ctrl_decoder
//   Fetch/decode stage in front of the 8-bit ARM datapath. Decodes the 24-bit
//   instruction word at the current PC into registered datapath controls and
//   sequences external interrupts (edge detect, pending latch, enable flag,
//   vector CALL injection).
//
//   Optional feature macro: ARM_DEC_ILLEGAL_TRAP_EN
//     defined   : opcodes E/F inject a CALL to TRAP_VEC regardless of ie
//     undefined : opcodes E/F decode as NOP
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   PC         in   8   current program counter from the datapath
//   instr      in  24   instruction word fetched from imem_addr
//   eint       in   1   external interrupt request (rising edge is the event)
//   imem_addr  out  8   program memory address (combinational copy of PC)
//   Literal    out  8   immediate / jump target
//   Addr       out  6   register operand address
//   calu       out  6   ALU operation
//   cpc        out  2   PC select: 0 load Literal, 1 PC+1, 2 skip-if-not-zero
//   csrc       out  2   register write source: 0 IN, 1 Literal, 2 MOV, 3 ALU/stack
//   cmsrc      out  3   MOV/stack mux select
//   wr_en      out  1   register file write enable
//   cal/ret/pop/push out 1 each  single-cycle stack strobes
//   ie         out  1   interrupt-enable flag
// ---------------------------------------------------------------------------
module arm_ctrl_decoder #(
  parameter logic [7:0] INT_VEC = 8'hF0
`ifdef ARM_DEC_ILLEGAL_TRAP_EN
  , parameter logic [7:0] TRAP_VEC = 8'hF8
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  PC,
  input  logic [23:0] instr,
  input  logic        eint,
  output logic [7:0]  imem_addr,
  output logic [7:0]  Literal,
  output logic [5:0]  Addr,
  output logic [5:0]  calu,
  output logic [1:0]  cpc,
  output logic [1:0]  csrc,
  output logic [2:0]  cmsrc,
  output logic        wr_en,
  output logic        cal,
  output logic        ret,
  output logic        pop,
  output logic        push,
  output logic        ie
);

  typedef enum logic [1:0] {
    ST_RST = 2'd0,
    ST_RUN = 2'd1,
    ST_INT = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_IN   = 4'h1,
    OP_LDI  = 4'h2,
    OP_MOV  = 4'h3,
    OP_ALU  = 4'h4,
    OP_JMP  = 4'h5,
    OP_CALL = 4'h6,
    OP_RET  = 4'h7,
    OP_PUSH = 4'h8,
    OP_POP  = 4'h9,
    OP_SKNE = 4'hA,
    OP_RETI = 4'hB,
    OP_EI   = 4'hC,
    OP_DI   = 4'hD,
    OP_UD_E = 4'hE,
    OP_UD_F = 4'hF
  } opcode_t;

  localparam logic [1:0] CPC_LIT  = 2'd0;
  localparam logic [1:0] CPC_INC  = 2'd1;
  localparam logic [1:0] CPC_SKIP = 2'd2;

  localparam logic [1:0] SRC_IN  = 2'd0;
  localparam logic [1:0] SRC_LIT = 2'd1;
  localparam logic [1:0] SRC_MOV = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd3;

  typedef struct packed {
    logic [7:0] literal;
    logic [5:0] addr;
    logic [5:0] calu;
    logic [1:0] cpc;
    logic [1:0] csrc;
    logic [2:0] cmsrc;
    logic       wr_en;
    logic       cal;
    logic       ret;
    logic       pop;
    logic       push;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    literal: 8'h00, addr: 6'h00, calu: 6'h00, cpc: CPC_INC, csrc: SRC_IN,
    cmsrc: 3'd0, wr_en: 1'b0, cal: 1'b0, ret: 1'b0, pop: 1'b0, push: 1'b0
  };

  state_t  state_q, state_d;
  ctrl_t   ctrl_q, ctrl_d;
  ctrl_t   nop_ctrl, dec_ctrl, int_ctrl;
  logic    ie_q, ie_d, dec_ie;
  logic    pend_q, pend_d;
  logic    eint_q;
  logic    rise, boundary, take;
  opcode_t opcode;

  assign imem_addr = PC;
  assign opcode    = opcode_t'(instr[23:20]);

  // Default field values shared by every opcode.
  always_comb begin
    nop_ctrl         = CTRL_RESET;
    nop_ctrl.literal = instr[7:0];
    nop_ctrl.addr    = instr[19:14];
  end

  // Injected vector CALL; the boundary instruction is not decoded so the
  // datapath pushes its PC and RETI resumes it.
  always_comb begin
    int_ctrl         = nop_ctrl;
    int_ctrl.literal = INT_VEC;
    int_ctrl.cpc     = CPC_LIT;
    int_ctrl.cal     = 1'b1;
  end

  // Plain instruction decode, independent of interrupt sequencing.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    dec_ctrl = nop_ctrl;
    dec_ie   = ie_q;
    unique case (opcode)
      OP_NOP: ;
      OP_IN: begin
        dec_ctrl.csrc  = SRC_IN;
        dec_ctrl.wr_en = 1'b1;
      end
      OP_LDI: begin
        dec_ctrl.csrc  = SRC_LIT;
        dec_ctrl.wr_en = 1'b1;
      end
      OP_MOV: begin
        dec_ctrl.csrc  = SRC_MOV;
        dec_ctrl.cmsrc = instr[10:8];
        dec_ctrl.wr_en = 1'b1;
      end
      OP_ALU: begin
        dec_ctrl.csrc  = SRC_ALU;
        dec_ctrl.calu  = instr[13:8];
        dec_ctrl.wr_en = 1'b1;
      end
      OP_JMP: dec_ctrl.cpc = CPC_LIT;
      OP_CALL: begin
        dec_ctrl.cpc = CPC_LIT;
        dec_ctrl.cal = 1'b1;
      end
      OP_RET: begin
        dec_ctrl.cpc = CPC_LIT;
        dec_ctrl.ret = 1'b1;
      end
      OP_PUSH: begin
        dec_ctrl.push = 1'b1;
        dec_ctrl.calu = instr[13:8];
      end
      OP_POP: begin
        dec_ctrl.pop   = 1'b1;
        dec_ctrl.csrc  = SRC_ALU;
        dec_ctrl.cmsrc = 3'd7;
        dec_ctrl.wr_en = 1'b1;
      end
      OP_SKNE: dec_ctrl.cpc = CPC_SKIP;
      OP_RETI: begin
        dec_ctrl.cpc = CPC_LIT;
        dec_ctrl.ret = 1'b1;
        dec_ie       = 1'b1;
      end
      OP_EI: dec_ie = 1'b1;
      OP_DI: dec_ie = 1'b0;
      OP_UD_E, OP_UD_F: begin
`ifdef ARM_DEC_ILLEGAL_TRAP_EN
        dec_ctrl.literal = TRAP_VEC;
        dec_ctrl.cpc     = CPC_LIT;
        dec_ctrl.cal     = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // A rising edge can be accepted in the same cycle it is seen; otherwise it
  // waits in pend. The cycle after any emitted PC load (JMP/CALL/RET/RETI,
  // trap or injection) is not an instruction boundary.
  assign rise     = eint & ~eint_q;
  assign boundary = (ctrl_q.cpc != CPC_LIT);
  assign take     = (state_q == ST_RUN) & boundary & ie_q & (pend_q | rise);

  // Next-state and next-control logic.
  always_comb begin
    state_d = state_q;
    ctrl_d  = dec_ctrl;
    ie_d    = ie_q;
    pend_d  = pend_q | rise;
    unique case (state_q)
      ST_RST: begin
        ctrl_d  = nop_ctrl;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (take) begin
          // Acceptance overrides whatever the boundary instruction (even DI) asked for.
          ctrl_d  = int_ctrl;
          ie_d    = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_INT;
        end else begin
          ie_d = dec_ie;
        end
      end
      ST_INT: begin
        ie_d    = dec_ie;
        state_d = ST_RUN;
      end
      default: begin
        ctrl_d  = CTRL_RESET;
        state_d = ST_RST;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RST;
      ctrl_q  <= CTRL_RESET;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      eint_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      eint_q  <= eint;
    end
  end

  assign Literal = ctrl_q.literal;
  assign Addr    = ctrl_q.addr;
  assign calu    = ctrl_q.calu;
  assign cpc     = ctrl_q.cpc;
  assign csrc    = ctrl_q.csrc;
  assign cmsrc   = ctrl_q.cmsrc;
  assign wr_en   = ctrl_q.wr_en;
  assign cal     = ctrl_q.cal;
  assign ret     = ctrl_q.ret;
  assign pop     = ctrl_q.pop;
  assign push    = ctrl_q.push;
  assign ie      = ie_q;

endmodule
